// File: rtl/gamecube_pkg.sv
// Shared definitions for the GameCube single-wire transmitter and the vbit timer.
// A data bit is four virtual bits: a 0 is L,L,L,H and a 1 is L,H,H,H, sent MSB first.
package gamecube_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } gc_state_t;

    localparam logic [3:0] GC_ZERO_PATTERN  = 4'b0001;
    localparam logic [3:0] GC_ONE_PATTERN   = 4'b0111;
    localparam int         GC_VBITS_PER_BIT = 4;
    localparam logic [1:0] GC_LAST_VBIT     = 2'(GC_VBITS_PER_BIT - 1);

    // Line level for virtual bit vbitIdx (0 = first on the wire) of a data bit.
    function automatic logic gcVbitLevel(input logic bitVal, input logic [1:0] vbitIdx);
        logic [3:0] pattern;
        pattern = bitVal ? GC_ONE_PATTERN : GC_ZERO_PATTERN;
        return pattern[2'd3 - vbitIdx];
    endfunction

endpackage

// File: rtl/gamecube_vbit_timer.sv
// Virtual-bit timer: counts 0..CYCLES_PER_VBIT-1 and flags the terminal count
// (tick) and the mid-point sample slot (mid). Held at zero while clear is high.
module gamecube_vbit_timer #(
    parameter int CYCLES_PER_VBIT = 1
) (
    input  logic CLK,
    input  logic n_RST,
    input  logic clear,
    output logic tick,
    output logic mid
);

    localparam int            CW       = (CYCLES_PER_VBIT > 1) ? $clog2(CYCLES_PER_VBIT) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(CYCLES_PER_VBIT - 1);
    localparam logic [CW-1:0] MIDPOINT = CW'(CYCLES_PER_VBIT / 2);

    logic [CW-1:0] r_count;

    // Free-running vbit counter that wraps on the terminal count so every vbit is the same width.
    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == TERMINAL);
    assign mid  = (r_count == MIDPOINT);

endmodule

// File: rtl/gamecube_frame_transmitter.sv
// GameCube dataline frame transmitter: one-entry holding register feeding a
// shift register that is serialised as 4-vbit symbols, followed by a stop bit.
// Optional feature macro: GC_TX_COLLISION_CHECK_EN adds DATALINE_IN/COLLISION and
// aborts the frame when the wire reads low while we are driving it high.
module gamecube_frame_transmitter
    import gamecube_pkg::*;
#(
    parameter int CYCLES_PER_VBIT = 1
) (
    input  logic       CLK,
    input  logic       n_RST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    input  logic       TX_LAST,
    output logic       TX_READY,
    output logic       DATALINE,
    output logic       DATALINE_OE,
    output logic       BUSY,
    output logic       DONE,
`ifdef GC_TX_COLLISION_CHECK_EN
    input  logic       DATALINE_IN,
    output logic       COLLISION,
`endif
    output logic       UNDERRUN
);

    gc_state_t  r_state;
    logic [2:0] r_bit_idx;
    logic [1:0] r_vbit_idx;
    logic [7:0] r_sh_data;
    logic       r_sh_last;
    logic [7:0] r_hold_data;
    logic       r_hold_last;
    logic       r_hold_valid;
    logic       r_dataline;
    logic       r_oe;
    logic       r_done;
    logic       r_underrun;

    logic       w_accept;
    logic       w_tick;
    logic       w_mid;
    logic       w_timer_clear;

    assign w_accept      = TX_VALID & ~r_hold_valid;
    assign w_timer_clear = (r_state == IDLE);

    gamecube_vbit_timer #(
        .CYCLES_PER_VBIT(CYCLES_PER_VBIT)
    ) u_vbit_timer (
        .CLK  (CLK),
        .n_RST(n_RST),
        .clear(w_timer_clear),
        .tick (w_tick),
        .mid  (w_mid)
    );

`ifdef GC_TX_COLLISION_CHECK_EN
    logic w_collision;
    logic r_collision;
    assign w_collision = (r_state != IDLE) && r_oe && r_dataline && w_mid && !DATALINE_IN;
    assign COLLISION   = r_collision;
`else
    logic w_unused_mid;
    assign w_unused_mid = w_mid;
`endif

    // Frame sequencer: holding register, shift register and registered line outputs,
    // where each line output is set to the level of the vbit that starts at this edge.
    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_vbit_idx   <= '0;
            r_sh_data    <= '0;
            r_sh_last    <= 1'b0;
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_dataline   <= 1'b1;
            r_oe         <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef GC_TX_COLLISION_CHECK_EN
            r_collision  <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
`ifdef GC_TX_COLLISION_CHECK_EN
            r_collision <= 1'b0;
`endif
            if (w_accept) begin
                r_hold_data  <= TX_DATA;
                r_hold_last  <= TX_LAST;
                r_hold_valid <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_dataline <= 1'b1;
                    r_oe       <= 1'b0;
                    if (r_hold_valid) begin
                        r_sh_data    <= r_hold_data;
                        r_sh_last    <= r_hold_last;
                        r_hold_valid <= 1'b0;
                        r_bit_idx    <= 3'd7;
                        r_vbit_idx   <= 2'd0;
                        r_dataline   <= gcVbitLevel(r_hold_data[7], 2'd0);
                        r_oe         <= 1'b1;
                        r_state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_vbit_idx != GC_LAST_VBIT) begin
                            r_vbit_idx <= r_vbit_idx + 2'd1;
                            r_dataline <= gcVbitLevel(r_sh_data[r_bit_idx], r_vbit_idx + 2'd1);
                        end else if (r_bit_idx != 3'd0) begin
                            r_bit_idx  <= r_bit_idx - 3'd1;
                            r_vbit_idx <= 2'd0;
                            r_dataline <= gcVbitLevel(r_sh_data[r_bit_idx - 3'd1], 2'd0);
                        end else if (r_sh_last) begin
                            r_vbit_idx <= 2'd0;
                            r_dataline <= 1'b0;
                            r_state    <= STOP;
                        end else if (r_hold_valid) begin
                            r_sh_data    <= r_hold_data;
                            r_sh_last    <= r_hold_last;
                            r_hold_valid <= 1'b0;
                            r_bit_idx    <= 3'd7;
                            r_vbit_idx   <= 2'd0;
                            r_dataline   <= gcVbitLevel(r_hold_data[7], 2'd0);
                        end else begin
                            r_underrun <= 1'b1;
                            r_vbit_idx <= 2'd0;
                            r_dataline <= 1'b0;
                            r_state    <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_vbit_idx == 2'd0) begin
                            r_vbit_idx <= 2'd1;
                            r_dataline <= 1'b1;
                        end else begin
                            r_vbit_idx <= 2'd0;
                            r_dataline <= 1'b1;
                            r_oe       <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: begin
                    r_dataline <= 1'b1;
                    r_oe       <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase

`ifdef GC_TX_COLLISION_CHECK_EN
            if (w_collision) begin
                r_collision <= 1'b1;
                r_dataline  <= 1'b1;
                r_oe        <= 1'b0;
                r_done      <= 1'b0;
                r_vbit_idx  <= 2'd0;
                r_state     <= IDLE;
            end
`endif
        end
    end

    assign TX_READY    = ~r_hold_valid;
    assign BUSY        = (r_state != IDLE);
    assign DATALINE    = r_dataline;
    assign DATALINE_OE = r_oe;
    assign DONE        = r_done;
    assign UNDERRUN    = r_underrun;

endmodule

// File: tb/tb_gamecube_frame_transmitter.sv
// Scoreboard bench for gamecube_frame_transmitter. The driver pushes the expected
// per-cycle line waveform of every frame it issues; a negedge monitor captures each
// frame the DUT sends and compares it. Honours GC_TX_COLLISION_CHECK_EN when defined.
module tb_gamecube_frame_transmitter;

    localparam int CPV   = 3;
    localparam int LIMIT = 3000;

    logic       CLK;
    logic       n_RST;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_LAST;
    logic       TX_READY;
    logic       DATALINE;
    logic       DATALINE_OE;
    logic       BUSY;
    logic       DONE;
    logic       UNDERRUN;

`ifdef GC_TX_COLLISION_CHECK_EN
    logic DATALINE_IN;
    logic COLLISION;
    bit   pullLow = 1'b0;
    assign DATALINE_IN = pullLow ? 1'b0 : (DATALINE_OE ? DATALINE : 1'b1);
`endif

    gamecube_frame_transmitter #(
        .CYCLES_PER_VBIT(CPV)
    ) dut (
        .CLK        (CLK),
        .n_RST      (n_RST),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_LAST    (TX_LAST),
        .TX_READY   (TX_READY),
        .DATALINE   (DATALINE),
        .DATALINE_OE(DATALINE_OE),
        .BUSY       (BUSY),
        .DONE       (DONE),
`ifdef GC_TX_COLLISION_CHECK_EN
        .DATALINE_IN(DATALINE_IN),
        .COLLISION  (COLLISION),
`endif
        .UNDERRUN   (UNDERRUN)
    );

    int   checks = 0;
    int   errors = 0;
    bit   expBits[$];
    int   expLen[$];
    int   expUr[$];
    logic [7:0] frameBytes[8];
    bit   skipFrame = 1'b0;

    // Free-running clock, 10 time units per cycle.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Reference: each data bit is a low first quarter, a high last quarter and the
    // bit value in between; then a low and a high stop vbit. Every vbit lasts CPV cycles.
    function automatic void pushExpected(input int n, input bit withLast);
        int  len;
        bit  level;
        len = 0;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                for (int v = 0; v < 4; v++) begin
                    if (v == 0)      level = 1'b0;
                    else if (v == 3) level = 1'b1;
                    else             level = frameBytes[i][b];
                    for (int c = 0; c < CPV; c++) begin
                        expBits.push_back(level);
                        len++;
                    end
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < CPV; c++) begin
                expBits.push_back(s == 1);
                len++;
            end
        end
        expLen.push_back(len);
        expUr.push_back(withLast ? 0 : 1);
    endfunction

    task automatic waitReady();
        int t;
        t = 0;
        while (!TX_READY && t < LIMIT) begin
            @(negedge CLK);
            t++;
        end
        checkOutput("txReadyWait", TX_READY, 1'b1);
    endtask

    // Issue frameBytes[0..n-1] back to back with TX_VALID held; called at a negedge.
    task automatic applyStimulus(input int n, input bit withLast, input bit track);
        if (track) pushExpected(n, withLast);
        for (int i = 0; i < n; i++) begin
            TX_DATA  = frameBytes[i];
            TX_LAST  = withLast && (i == n - 1);
            TX_VALID = 1'b1;
            waitReady();
            @(posedge CLK);
            @(negedge CLK);
        end
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (!(TX_READY && !BUSY) && t < LIMIT) begin
            @(negedge CLK);
            t++;
        end
        checkOutput("idleReached", {TX_READY, BUSY}, 2'b10);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (expLen.size() != 0 && t < LIMIT) begin
            @(negedge CLK);
            t++;
        end
        checkOutput("scoreboardDrained", expLen.size(), 0);
    endtask

    // Monitor: capture the line while BUSY, score the frame when BUSY falls,
    // and check the released idle line otherwise.
    bit wave[$];
    int urCount = 0;
    int oeBad = 0;
    bit inFrame = 1'b0;
    always @(negedge CLK) begin
        int eLen;
        int eUr;
        int mism;
        bit b;
        if (!n_RST) begin
            wave.delete();
            urCount = 0;
            oeBad   = 0;
            inFrame = 1'b0;
        end else if (BUSY) begin
            inFrame = 1'b1;
            wave.push_back(DATALINE);
            if (DATALINE_OE !== 1'b1) oeBad++;
            if (UNDERRUN === 1'b1) urCount++;
        end else if (inFrame) begin
            if (!skipFrame) begin
                if (expLen.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedFrame: got a frame of %0d cycles expected none", wave.size());
                end else begin
                    eLen = expLen.pop_front();
                    eUr  = expUr.pop_front();
                    mism = 0;
                    for (int i = 0; i < eLen; i++) begin
                        b = expBits.pop_front();
                        if (i >= wave.size() || wave[i] !== b) mism++;
                    end
                    checkOutput("frameLength", wave.size(), eLen);
                    checkOutput("waveMismatches", mism, 0);
                    checkOutput("underrunPulses", urCount, eUr);
                    checkOutput("oeDropsInFrame", oeBad, 0);
                    checkOutput("doneAndRelease", {DONE, DATALINE, DATALINE_OE}, 3'b110);
                end
            end
            wave.delete();
            urCount = 0;
            oeBad   = 0;
            inFrame = 1'b0;
        end else begin
            checkOutput("idleLine", {DATALINE, DATALINE_OE, DONE, UNDERRUN}, 4'b1000);
        end
    end

    // Directed cases, a randomized frame mix, mid-frame reset and optional collision.
    initial begin
        int  n;
        bit  withLast;
        int  t;
        int  doneSeen;

        n_RST    = 1'b0;
        TX_DATA  = '0;
        TX_VALID = 1'b0;
        TX_LAST  = 1'b0;
        #12;
        checkOutput("resetOutputs", {DATALINE, DATALINE_OE, TX_READY, BUSY, DONE, UNDERRUN}, 6'b101000);
        @(negedge CLK);
        n_RST = 1'b1;
        @(negedge CLK);

        frameBytes[0] = 8'h40;
        applyStimulus(1, 1'b1, 1'b1);

        frameBytes[0] = 8'h40;
        frameBytes[1] = 8'h03;
        frameBytes[2] = 8'h00;
        applyStimulus(3, 1'b1, 1'b1);

        frameBytes[0] = 8'h40;
        applyStimulus(1, 1'b0, 1'b1);
        waitIdle();

        frameBytes[0] = 8'hFF;
        applyStimulus(1, 1'b1, 1'b1);

        for (int f = 0; f < 12; f++) begin
            n        = $urandom_range(1, 4);
            withLast = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) frameBytes[i] = 8'($urandom);
            applyStimulus(n, withLast, 1'b1);
            if (!withLast) waitIdle();
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        waitIdle();
        waitDrain();

        frameBytes[0] = 8'h55;
        applyStimulus(1, 1'b1, 1'b0);
        t = 0;
        while (!BUSY && t < LIMIT) begin
            @(negedge CLK);
            t++;
        end
        checkOutput("busyBeforeReset", BUSY, 1'b1);
        repeat ((4 * 4 + 1) * CPV) @(negedge CLK);
        #2 n_RST = 1'b0;
        #1;
        checkOutput("midFrameReset", {DATALINE, DATALINE_OE, BUSY, TX_READY, DONE}, 5'b10010);
        repeat (2) @(negedge CLK);
        n_RST = 1'b1;
        @(negedge CLK);
        checkOutput("readyAfterReset", TX_READY, 1'b1);
        frameBytes[0] = 8'hA5;
        applyStimulus(1, 1'b1, 1'b1);
        waitIdle();
        waitDrain();

`ifdef GC_TX_COLLISION_CHECK_EN
        skipFrame     = 1'b1;
        frameBytes[0] = 8'h80;
        applyStimulus(1, 1'b1, 1'b0);
        t = 0;
        while (!(DATALINE_OE && DATALINE) && t < LIMIT) begin
            @(negedge CLK);
            t++;
        end
        checkOutput("drivenHighSeen", {DATALINE_OE, DATALINE}, 2'b11);
        pullLow = 1'b1;
        t = 0;
        while (COLLISION !== 1'b1 && t < 4 * CPV) begin
            @(negedge CLK);
            t++;
        end
        checkOutput("collisionAbort", {COLLISION, DATALINE_OE, BUSY, DONE}, 4'b1000);
        pullLow  = 1'b0;
        doneSeen = 0;
        repeat (4 * CPV) begin
            @(negedge CLK);
            if (DONE === 1'b1) doneSeen++;
        end
        checkOutput("noDoneAfterCollision", doneSeen, 0);
        skipFrame = 1'b0;
`endif

        checkOutput("noPendingFrames", expLen.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
